// File: rtl/pvp_pkg.sv
// ---------------------------------------------------------------------------
// pvp_pkg
//   Shared definitions for the PvP end-of-match result screens.
//   - result-code constants (RES_NONE and a helper for the draw code, which
//     depends on the player count of the instantiating block)
//   - result sequencer state encoding
//   - RGB565 pixel width
// ---------------------------------------------------------------------------
package pvp_pkg;

    localparam int RGB565_W = 16;

    // "No result yet" code on the result bus.
    localparam int RES_NONE = 0;

    // The draw code sits one above the highest player number.
    function automatic int res_draw(input int num_players);
        return num_players + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ANIM = 2'd1,
        ST_SHOW = 2'd2
    } seq_state_t;

endpackage : pvp_pkg

// File: rtl/frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen
//   Single-cycle frame tick derived from the system clock, replacing a
//   separately divided frame clock so everything stays on clk.
//
//   Parameters: CLK_HZ, FRAME_RATE (tick period = CLK_HZ / FRAME_RATE clocks)
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-high reset
//     en     in   count enable; counter clears synchronously while low
//     tick   out  high for one clock when the count reaches TICK_DIV-1
// ---------------------------------------------------------------------------
module frame_tick_gen #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FRAME_RATE = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int TICK_DIV = CLK_HZ / FRAME_RATE;
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (!en) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Gated by en so a stale count can never produce a tick while idle.
    assign tick = en && (cnt_reg == CNT_LAST);

endmodule : frame_tick_gen

// File: rtl/pvp_result_sequencer.sv
// ---------------------------------------------------------------------------
// pvp_result_sequencer
//   End-of-match result controller for N players. A win plays ANIM_FRAMES
//   animation frames then shows the result screen; a draw goes straight to
//   the result screen. The result banner blinks on the result screen.
//   Sprite ROMs live outside; they are addressed by winner / anim_frame and
//   their pixels are composited here into the OLED stream.
//
//   Ports:
//     clk           in   system clock
//     reset         in   asynchronous active-high reset
//     result        in   0 none, 1..NUM_PLAYERS winner, NUM_PLAYERS+1 draw
//     base_pixel    in   game-over base layer pixel (RGB565)
//     banner_pixel  in   result banner pixel
//     anim_pixel    in   animation sprite pixel
//     winner        out  latched result code, 0 while idle
//     anim_frame    out  current animation frame index
//     anim_active   out  high while animating
//     done          out  high while showing the result screen
//     oled_data     out  composited pixel
// ---------------------------------------------------------------------------
module pvp_result_sequencer
    import pvp_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int FRAME_RATE   = 6,
    parameter int NUM_PLAYERS  = 2,
    parameter int ANIM_FRAMES  = 8,
    parameter int BLINK_FRAMES = 3,
    parameter int RW           = $clog2(NUM_PLAYERS + 2),
    parameter int AFW          = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RW-1:0]       result,
    input  logic [RGB565_W-1:0] base_pixel,
    input  logic [RGB565_W-1:0] banner_pixel,
    input  logic [RGB565_W-1:0] anim_pixel,
    output logic [RW-1:0]       winner,
    output logic [AFW-1:0]      anim_frame,
    output logic                anim_active,
    output logic                done,
    output logic [RGB565_W-1:0] oled_data
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [RW-1:0]  CODE_LAST_PLAYER = RW'(NUM_PLAYERS);
    localparam logic [RW-1:0]  CODE_DRAW        = RW'(res_draw(NUM_PLAYERS));
    localparam logic [AFW-1:0] FRAME_LAST       = AFW'(ANIM_FRAMES - 1);
    localparam logic [BW-1:0]  BLINK_LAST       = BW'(BLINK_FRAMES - 1);

    seq_state_t    state_reg;
    logic [RW-1:0] winner_reg;
    logic [AFW-1:0] anim_frame_reg;
    logic          anim_active_reg;
    logic          done_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          phase_on_reg;

    logic is_win;
    logic is_draw;
    logic res_valid;
    logic tick;
    logic tick_en;

    // Codes above the draw code are treated exactly like "no result".
    assign is_win    = (result != RW'(RES_NONE)) && (result <= CODE_LAST_PLAYER);
    assign is_draw   = (result == CODE_DRAW);
    assign res_valid = is_win || is_draw;

    // Dropping the enable as soon as the result goes away clears the tick
    // counter on the same edge that returns the FSM to IDLE.
    assign tick_en = (state_reg != ST_IDLE) && res_valid;

    frame_tick_gen #(
        .CLK_HZ     (CLK_HZ),
        .FRAME_RATE (FRAME_RATE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            winner_reg      <= '0;
            anim_frame_reg  <= '0;
            anim_active_reg <= 1'b0;
            done_reg        <= 1'b0;
            blink_cnt_reg   <= '0;
            phase_on_reg    <= 1'b1;
        end else if (state_reg != ST_IDLE && !res_valid) begin
            // Result withdrawn: abandon the sequence; this also beats a
            // coinciding final animation tick.
            state_reg       <= ST_IDLE;
            winner_reg      <= '0;
            anim_frame_reg  <= '0;
            anim_active_reg <= 1'b0;
            done_reg        <= 1'b0;
            blink_cnt_reg   <= '0;
            phase_on_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    blink_cnt_reg <= '0;
                    phase_on_reg  <= 1'b1;
                    if (is_win) begin
                        state_reg       <= ST_ANIM;
                        winner_reg      <= result;
                        anim_frame_reg  <= '0;
                        anim_active_reg <= 1'b1;
                    end else if (is_draw) begin
                        state_reg  <= ST_SHOW;
                        winner_reg <= result;
                        done_reg   <= 1'b1;
                    end
                end
                ST_ANIM: begin
                    if (tick) begin
                        if (anim_frame_reg == FRAME_LAST) begin
                            // Last frame index stays on the output in SHOW.
                            state_reg       <= ST_SHOW;
                            anim_active_reg <= 1'b0;
                            done_reg        <= 1'b1;
                        end else begin
                            anim_frame_reg <= anim_frame_reg + 1'b1;
                        end
                    end
                end
                ST_SHOW: begin
                    if (tick) begin
                        if (blink_cnt_reg == BLINK_LAST) begin
                            blink_cnt_reg <= '0;
                            phase_on_reg  <= ~phase_on_reg;
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    winner_reg      <= '0;
                    anim_frame_reg  <= '0;
                    anim_active_reg <= 1'b0;
                    done_reg        <= 1'b0;
                    blink_cnt_reg   <= '0;
                    phase_on_reg    <= 1'b1;
                end
            endcase
        end
    end

    // Pixel path is purely combinational so the external ROM latency is
    // the only latency seen by the OLED driver.
    always_comb begin
        oled_data = '0;
        case (state_reg)
            ST_ANIM: oled_data = anim_pixel;
            ST_SHOW: oled_data = base_pixel | (phase_on_reg ? banner_pixel : '0);
            default: oled_data = '0;
        endcase
    end

    assign winner      = winner_reg;
    assign anim_frame  = anim_frame_reg;
    assign anim_active = anim_active_reg;
    assign done        = done_reg;

endmodule : pvp_result_sequencer

// File: doc/pvp_result_sequencer.md
# pvp_result_sequencer

Parametrised end-of-match result controller for the PvP game screens. It generalises the fixed two-player X/O final-result display to N players, adds an explicit draw outcome, and adds a blinking result banner. It derives its own frame tick from the system clock and sequences win-animation frames, then the result screen. It composites externally supplied sprite-ROM pixels into the OLED pixel stream, and sits between the game-state logic (`result` code) and the JB OLED driver.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency
- `FRAME_RATE`, 6, animation frames per second; tick period `TICK_DIV = CLK_HZ / FRAME_RATE` clocks
- `NUM_PLAYERS`, 2, number of players, 2..4
- `ANIM_FRAMES`, 8, win-animation length in frames, ≥1
- `BLINK_FRAMES`, 3, banner on/off half-period in frames, ≥1
- `RW`, `$clog2(NUM_PLAYERS+2)`, width of result code
- `clk  in  1`  system clock
- `reset  in  1`  asynchronous, active-high reset
- `result  in  RW`  0 = no result; 1..NUM_PLAYERS = that player won; NUM_PLAYERS+1 = draw; other codes are treated as 0
- `base_pixel  in  16`  game-over base layer pixel (RGB565)
- `banner_pixel  in  16`  result banner pixel, selected externally by `winner`
- `anim_pixel  in  16`  animation sprite pixel, selected externally by `winner`/`anim_frame`
- `winner  out  RW`  latched result code; 0 while idle
- `anim_frame  out  $clog2(ANIM_FRAMES)` (min 1)  current animation frame index
- `anim_active  out  1`  high in ANIM
- `done  out  1`  high in SHOW
- `oled_data  out  16`  composited pixel

## Operation
- States: IDLE, ANIM, SHOW.
- IDLE: `oled_data=0`, `winner=0`, `anim_frame=0`, blink phase = on.
- IDLE → ANIM when `result` ∈ 1..NUM_PLAYERS. Latch `winner`, zero the tick counter and `anim_frame`.
- IDLE → SHOW directly when `result`=NUM_PLAYERS+1 (draw has no animation). Latch `winner`, zero the tick counter.
- ANIM: on each tick, `anim_frame`++. The tick that ends frame ANIM_FRAMES-1 moves to SHOW (`anim_frame` holds at ANIM_FRAMES-1). `oled_data = anim_pixel`.
- SHOW: the blink counter counts ticks and toggles the blink phase every BLINK_FRAMES ticks. `oled_data = base_pixel | (phase_on ? banner_pixel : 0)`. Stays in SHOW indefinitely.
- From any non-IDLE state, `result`=0 (or an invalid code) → IDLE next clock. All counters clear.
- A changed nonzero `result` while in ANIM/SHOW is ignored. The latched winner holds until `result` returns to 0.
- Tick counter: 0..TICK_DIV-1. The tick pulses when the count equals TICK_DIV-1, then wraps to 0. It runs only outside IDLE.

## Timing
- Reset values: state IDLE, `winner=0`, `anim_frame=0`, `anim_active=0`, `done=0`, `oled_data=0`, blink phase on.
- `result` is sampled on the rising edge of `clk`. State and `winner` change on the edge where a valid code is first seen, so there is 1 clk latency.
- The first animation frame lasts exactly TICK_DIV clocks. Total ANIM duration is ANIM_FRAMES × TICK_DIV clocks.
- `oled_data` is combinational from registered state, the phase bit and the pixel inputs. It adds no latency to the pixel path.
- `done` and `anim_active` are registered state decodes and are never high together.
- Asserting `reset` mid-operation forces reset values immediately, without waiting for a clock edge.
- Simultaneous events: if the final ANIM tick coincides with `result`=0, IDLE wins.

## Structure
- Shared package `pvp_pkg`:
  - result-code localparams (`RES_NONE=0`, `RES_DRAW=NUM_PLAYERS+1`)
  - state enum encoding
  - RGB565 width constant
- One sub-module, `frame_tick_gen`:
  - parameters CLK_HZ, FRAME_RATE
  - ports `clk`, `reset`, `en`, `tick`
  - synchronous clear when `en` is low
  - replaces the free-running divided frame clock, so the whole block stays on one clock domain.
- The sprite ROMs stay outside this block. They are driven by `winner` and `anim_frame`.

## Test plan
Common settings: CLK_HZ=60, FRAME_RATE=6 (TICK_DIV=10), ANIM_FRAMES=4, BLINK_FRAMES=2, NUM_PLAYERS=2, with pixel inputs base=16'h0001, banner=16'h0100, anim=16'hF000.
- Reset, then `result`=0 for 50 clks → `oled_data=0`, `winner=0`, `done=0` throughout.
- `result`=1 held → next clk `winner=1`, `anim_active=1`, `oled_data=F000`. `anim_frame` reads 1, 2, 3 at +10, +20, +30 clks. At +40, `done=1` and `oled_data=0101`.
- In SHOW: `oled_data` alternates 0101 (20 clks) / 0001 (20 clks) repeatedly.
- `result`=3 (draw) → next clk `done=1`, `winner=3`, `anim_active=0`, with no animation.
- `result`=1, then `result` changes to 2 at clk 15 → `winner` stays 1. `result`=0 at clk 25 → IDLE on the next clk, `anim_frame=0`, `oled_data=0`. A later `result`=2 restarts a full 40-clk animation.
- Assert `reset` asynchronously mid-ANIM, off a clock edge → all outputs go to reset values before the next edge. Deassert with `result`=2 → the animation restarts from frame 0.
